// File: rtl/fmap_ram_stream_reader.sv
// rtl/fmap_ram_stream_reader.sv - sequential RAM port-B reader feeding a valid/ready stream
module fmap_ram_stream_reader #(
  parameter int WIDTH    = 8,
  parameter int ADDR_BIT = 10,
  parameter int DEPTH    = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT-1:0] base_addr,
  input  logic [ADDR_BIT:0]   length,
  output logic                busy,
  output logic                done,
  output logic                ram_en,
  output logic [ADDR_BIT-1:0] ram_addr,
  input  logic [WIDTH-1:0]    ram_dout,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WIDTH-1:0]    m_data
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FINISH} state_t;

  state_t              state, state_nx;
  logic [ADDR_BIT-1:0] next_addr;   // address of the next read to issue
  logic [ADDR_BIT-1:0] held_addr;   // last issued address, shown while not issuing
  logic [ADDR_BIT:0]   remaining;
  logic                inflight;    // a read was issued last cycle; its data is on ram_dout now
  logic [1:0]          fifo_cnt;
  logic [WIDTH-1:0]    head, tail;
  logic                pop, push, accept;
  logic [2:0]          occ;

  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign accept  = (state == IDLE) && start;
  assign m_valid = (fifo_cnt != 2'd0);
  assign m_data  = head;
  // Slots already claimed: words held in the FIFO plus the word still coming out of the RAM.
  assign occ     = {1'b0, fifo_cnt} + {2'b00, inflight};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state, issue decision and status outputs.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    ram_en   = 1'b0;
    ram_addr = held_addr;
    case (state)
      IDLE: begin
        ram_addr = '0;
        if (start) state_nx = (length == '0) ? FINISH : READ;
      end
      READ: begin
        busy = 1'b1;
        // Issue only if the word will have a FIFO slot when it lands, counting this cycle's pop.
        if ((remaining != '0) && (occ < (3'd2 + {2'b00, pop}))) begin
          ram_en   = 1'b1;
          ram_addr = next_addr;
          if (remaining == (ADDR_BIT+1)'(1)) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave as soon as the last word is being accepted so done follows it directly.
        if (!inflight && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) state_nx = FINISH;
      end
      FINISH: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Read address / count bookkeeping and the in-flight marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_addr <= '0;
      held_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= ram_en;
      if (accept) begin
        next_addr <= base_addr;
        remaining <= length;
      end else if (ram_en) begin
        held_addr <= next_addr;
        next_addr <= (next_addr == ADDR_BIT'(DEPTH - 1)) ? '0 : next_addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  // Two-entry output FIFO; head always drives m_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
      head     <= '0;
      tail     <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) head <= ram_dout;
          else                  tail <= ram_dout;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          head     <= tail;
          fifo_cnt <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd1) begin
            head <= ram_dout;
          end else begin
            head <= tail;
            tail <= ram_dout;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue rule must never let claimed slots exceed the FIFO size.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) occ <= 3'd2);

endmodule
